// File: rtl/mp_add_seq_if.sv
// mp_add_seq_if: operand/result handshake bundle for mp_add_seq.
// Optional sub field exists only when MP_ADD_SUB_EN is defined.
interface mp_add_seq_if #(
  parameter int WORDS = 4
);
  localparam int W = 16 * WORDS;

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
`ifdef MP_ADD_SUB_EN
  logic         sub;
`endif
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
  logic         busy;

  modport master (
`ifdef MP_ADD_SUB_EN
    output sub,
`endif
    output in_valid,
    output a,
    output b,
    output cin,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  sum,
    input  cout,
    input  busy
  );

  modport slave (
`ifdef MP_ADD_SUB_EN
    input  sub,
`endif
    input  in_valid,
    input  a,
    input  b,
    input  cin,
    input  out_ready,
    output in_ready,
    output out_valid,
    output sum,
    output cout,
    output busy
  );

endinterface

// File: rtl/mp_add_seq.sv
// mp_add_seq: multi-precision adder, one 16-bit word per clock, LSW first.
// Define MP_ADD_SUB_EN to add the sub input (a - b via inverted b, carry-in 1).
module mp_add_seq #(
  parameter int WORDS = 4
) (
  input  logic         clk,
  input  logic         rst,
  mp_add_seq_if.slave  bus
);

  localparam int W  = 16 * WORDS;
  localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t        r_state;
  state_t        w_next;

  logic [W-1:0]  r_a;
  logic [W-1:0]  r_b;
  logic [W-1:0]  r_sum;
  logic          r_carry;
  logic          r_cout;
  logic [IW-1:0] r_idx;

  logic          w_in_ready;
  logic          w_out_valid;
  logic          w_busy;
  logic          w_acc;
  logic          w_rel;
  logic          w_last;
  logic [15:0]   w_aw;
  logic [15:0]   w_bw;
  logic [16:0]   w_add;
  logic [W-1:0]  w_b_in;
  logic          w_c_in;

  assign w_acc  = bus.in_valid & w_in_ready;
  assign w_rel  = w_out_valid & bus.out_ready;
  assign w_last = (r_idx == IW'(WORDS - 1));

  assign w_aw  = r_a[{r_idx, 4'b0000} +: 16];
  assign w_bw  = r_b[{r_idx, 4'b0000} +: 16];
  // Full 17-bit add so the carry is the true bit 16 of the word sum.
  assign w_add = {1'b0, w_aw} + {1'b0, w_bw} + {16'b0, r_carry};

  // Operand conditioning at accept: subtract folds into inverted b, carry 1.
  always_comb begin
    w_b_in = bus.b;
    w_c_in = bus.cin;
`ifdef MP_ADD_SUB_EN
    if (bus.sub) begin
      w_b_in = ~bus.b;
      w_c_in = 1'b1;
    end
`endif
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state decode.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: if (w_acc) w_next = S_RUN;
      S_RUN:  if (w_last) w_next = S_DONE;
      S_DONE: if (w_rel) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Handshake/status outputs are pure state decodes.
  always_comb begin
    w_in_ready  = 1'b0;
    w_out_valid = 1'b0;
    w_busy      = 1'b0;
    unique case (r_state)
      S_IDLE: w_in_ready = 1'b1;
      S_RUN:  w_busy = 1'b1;
      S_DONE: begin
        w_out_valid = 1'b1;
        w_busy      = 1'b1;
      end
      default: w_in_ready = 1'b0;
    endcase
  end

  // Datapath: capture operands at accept, then one word per RUN cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_carry <= 1'b0;
      r_cout  <= 1'b0;
      r_idx   <= '0;
    end else if (w_acc) begin
      r_a     <= bus.a;
      r_b     <= w_b_in;
      r_carry <= w_c_in;
      r_idx   <= '0;
    end else if (r_state == S_RUN) begin
      r_sum[{r_idx, 4'b0000} +: 16] <= w_add[15:0];
      r_carry <= w_add[16];
      if (w_last) begin
        r_cout <= w_add[16];
        r_idx  <= '0;
      end else begin
        r_idx  <= r_idx + 1'b1;
      end
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = w_out_valid;
  assign bus.busy      = w_busy;
  assign bus.sum       = r_sum;
  assign bus.cout      = r_cout;

endmodule

// File: tb/tb_mp_add_seq.sv
// tb_mp_add_seq: directed + random scoreboard bench for mp_add_seq.
// Subtract cases run only when MP_ADD_SUB_EN is defined.
module tb_mp_add_seq;

  localparam int WORDS = 4;
  localparam int W     = 16 * WORDS;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  mp_add_seq_if #(.WORDS(WORDS)) bus ();

  mp_add_seq #(.WORDS(WORDS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;
  logic [64:0] sb[$];

  task automatic chk(input string tag,
                     input logic [64:0] obs,
                     input logic [64:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [64:0] model(input logic [W-1:0] a,
                                        input logic [W-1:0] b,
                                        input logic cin,
                                        input logic sub);
    logic [64:0] r;
    if (sub) r = {1'b0, a} + {1'b0, ~b} + 65'd1;
    else     r = {1'b0, a} + {1'b0, b} + {64'b0, cin};
    return r;
  endfunction

  task automatic drive(input logic [W-1:0] a,
                       input logic [W-1:0] b,
                       input logic cin,
                       input logic sub);
    bus.in_valid = 1'b1;
    bus.a        = a;
    bus.b        = b;
    bus.cin      = cin;
`ifdef MP_ADD_SUB_EN
    bus.sub      = sub;
`endif
    sb.push_back(model(a, b, cin, sub));
  endtask

  task automatic wait_out(output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!bus.out_valid && n < 40);
    if (!bus.out_valid) chk("out_valid_timeout", 65'd0, 65'd1);
  endtask

  localparam logic [63:0] T2A = 64'h0001_0002_0003_0004;
  localparam logic [63:0] T2B = 64'h0010_0020_0030_0040;
  localparam logic [64:0] T2R = {1'b0, 64'h0011_0022_0033_0045};

  initial begin
    int n;
    int acc_n;
    int rel_n;
    int cyc;
    bit pend;
    bit acc;
    bit rel;
    logic [64:0] obs;
    logic [64:0] exp1;
    logic [64:0] cur;
    logic [63:0] ra;
    logic [63:0] rb;
    logic        rc;
    logic        rs;

    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.cin       = 1'b0;
`ifdef MP_ADD_SUB_EN
    bus.sub       = 1'b0;
`endif

    // Reset state
    tick();
    chk("rst_flags", 65'({bus.in_ready, bus.out_valid, bus.busy, bus.cout}),
        65'(4'b1000));
    chk("rst_sum", {1'b0, bus.sum}, 65'd0);
    rst = 1'b0;
    tick();

    // Test 1: full carry ripple, latency, operand sampling
    drive(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0);
    tick();
    bus.in_valid = 1'b0;
    bus.a        = 64'h1234_5678_9ABC_DEF0;
    bus.b        = 64'hFFFF_0000_FFFF_0000;
    bus.cin      = 1'b1;
    chk("run_flags", 65'({bus.busy, bus.in_ready}), 65'(2'b10));
    wait_out(n);
    chk("lat1", 65'(n), 65'd4);
    exp1 = sb.pop_front();
    chk("res1_model", {bus.cout, bus.sum}, exp1);
    chk("res1_const", {bus.cout, bus.sum}, {1'b1, 64'd0});

    // Test 3: backpressure with pending in_valid
    drive(T2A, T2B, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_hold", {bus.cout, bus.sum}, exp1);
      chk("bp_flags", 65'({bus.in_ready, bus.out_valid}), 65'(2'b01));
    end
    bus.out_ready = 1'b1;
    tick();
    chk("bp_idle", 65'({bus.in_ready, bus.out_valid, bus.busy}), 65'(3'b100));
    bus.out_ready = 1'b0;
    tick();
    chk("bp_accept", 65'({bus.in_ready, bus.busy}), 65'(2'b01));
    bus.in_valid = 1'b0;
    wait_out(n);
    chk("lat2", 65'(n), 65'd4);
    chk("res2_model", {bus.cout, bus.sum}, sb.pop_front());
    chk("res2_const", {bus.cout, bus.sum}, T2R);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;

    // Test 4: reset during RUN aborts
    drive(T2A, T2B, 1'b1, 1'b0);
    tick();
    bus.in_valid = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_flags",
        65'({bus.in_ready, bus.out_valid, bus.busy, bus.cout}), 65'(4'b1000));
    chk("abort_sum", {1'b0, bus.sum}, 65'd0);
    void'(sb.pop_back());
    drive(T2A, T2B, 1'b1, 1'b0);
    tick();
    bus.in_valid = 1'b0;
    wait_out(n);
    chk("rerun_lat", 65'(n), 65'd4);
    chk("rerun_res", {bus.cout, bus.sum}, sb.pop_front());
    chk("rerun_const", {bus.cout, bus.sum}, T2R);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;

`ifdef MP_ADD_SUB_EN
    // Test 5: subtraction, cin ignored
    drive(64'd5, 64'd7, 1'b1, 1'b1);
    tick();
    bus.in_valid = 1'b0;
    wait_out(n);
    chk("sub_neg_model", {bus.cout, bus.sum}, sb.pop_front());
    chk("sub_neg_const", {bus.cout, bus.sum}, {1'b0, 64'hFFFF_FFFF_FFFF_FFFE});
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    drive(64'd7, 64'd5, 1'b0, 1'b1);
    tick();
    bus.in_valid = 1'b0;
    wait_out(n);
    chk("sub_pos_model", {bus.cout, bus.sum}, sb.pop_front());
    chk("sub_pos_const", {bus.cout, bus.sum}, {1'b1, 64'd2});
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
`endif

    // Test 6: random back-to-back ops with stalls
    acc_n = 0;
    rel_n = 0;
    cyc   = 0;
    pend  = 1'b0;
    cur   = '0;
    while ((acc_n < 1000 || rel_n < acc_n) && cyc < 40000) begin
      if (!pend && acc_n < 1000 && $urandom_range(0, 3) != 0) begin
        ra = {$urandom, $urandom};
        rb = {$urandom, $urandom};
        if ($urandom_range(0, 3) == 0) ra = 64'hFFFF_FFFF_FFFF_FFFF;
        if ($urandom_range(0, 5) == 0) rb = 64'd0;
        rc = 1'($urandom_range(0, 1));
        rs = 1'b0;
`ifdef MP_ADD_SUB_EN
        rs = 1'($urandom_range(0, 1));
        bus.sub = rs;
`endif
        bus.a        = ra;
        bus.b        = rb;
        bus.cin      = rc;
        bus.in_valid = 1'b1;
        cur  = model(ra, rb, rc, rs);
        pend = 1'b1;
      end
      bus.out_ready = ($urandom_range(0, 2) != 0);
      acc = bus.in_valid & bus.in_ready;
      rel = bus.out_valid & bus.out_ready;
      obs = {bus.cout, bus.sum};
      tick();
      cyc++;
      if (acc) begin
        sb.push_back(cur);
        acc_n++;
        pend         = 1'b0;
        bus.in_valid = 1'b0;
      end
      if (rel) begin
        rel_n++;
        if (sb.size() == 0) chk("rnd_dup", 65'd1, 65'd0);
        else chk("rnd_res", obs, sb.pop_front());
      end
    end
    bus.out_ready = 1'b0;
    chk("rnd_accepts", 65'(acc_n), 65'd1000);
    chk("rnd_results", 65'(rel_n), 65'd1000);
    chk("rnd_sb_empty", 65'(sb.size()), 65'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
